// File: rtl/digdug_scandoubler_if.sv
`default_nettype none
// ============================================================================
// Module      : digdug_scandoubler_if
// Description : Pixel-in / doubled-video-out bundle for the DigDug scandoubler.
// Revision    : 1.0 - initial release
// ============================================================================
interface digdug_scandoubler_if;
    logic       PCLK;
    logic [8:0] PH;
    logic [8:0] PV;
    logic [7:0] POUT;
    logic       O_PCE;
    logic       O_HS;
    logic       O_VS;
    logic       O_DE;
    logic [7:0] O_RGB;

    modport master (
        output PCLK, PH, PV, POUT,
        input  O_PCE, O_HS, O_VS, O_DE, O_RGB
    );

    modport slave (
        input  PCLK, PH, PV, POUT,
        output O_PCE, O_HS, O_VS, O_DE, O_RGB
    );
endinterface
`default_nettype wire

// File: rtl/digdug_scandoubler.sv
`default_nettype none
// ============================================================================
// Module      : digdug_scandoubler
// Description : Ping-pong line-buffer scandoubler, 15 kHz pixel stream in,
//               each line played twice at 31 kHz, all in the MCLK domain.
// Revision    : 1.0 - initial release
// ============================================================================
module digdug_scandoubler #(
    parameter int H_ACTIVE = 288,
    parameter int H_TOTAL  = 384,
    parameter int V_ACTIVE = 224,
    parameter int PIX_DIV  = 4,
    parameter int HS_START = 304,
    parameter int HS_WIDTH = 32,
    parameter int VS_START = 240,
    parameter int VS_WIDTH = 3
) (
    input  wire logic            MCLK,
    input  wire logic            RESET_N,
    digdug_scandoubler_if.slave  vid
);

    localparam int         c_DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(PIX_DIV - 1);
    localparam logic [8:0] c_H_ACTIVE = 9'(H_ACTIVE);
    localparam logic [8:0] c_H_LAST   = 9'(H_TOTAL - 1);
    localparam logic [8:0] c_V_ACTIVE = 9'(V_ACTIVE);
    localparam logic [8:0] c_HS_START = 9'(HS_START);
    localparam logic [8:0] c_HS_END   = 9'(HS_START + HS_WIDTH);
    localparam logic [8:0] c_VS_START = 9'(VS_START);
    localparam logic [8:0] c_VS_END   = 9'(VS_START + VS_WIDTH);

    logic               r_pclk;
    logic [c_DIV_W-1:0] r_div;
    logic [8:0]         r_ox;
    logic [8:0]         r_pv_play;
    logic               r_wsel;
    logic               r_seen_start;
    logic               r_line_valid;
    logic               r_pce;

    logic               r_ld;
    logic               r_s1_de;
    logic               r_s1_hs;
    logic               r_s1_vs;
    logic [7:0]         r_rd_data;

    logic               r_out_hs;
    logic               r_out_vs;
    logic               r_out_de;
    logic [7:0]         r_out_rgb;

    logic [7:0]         r_mem0 [0:H_ACTIVE-1];
    logic [7:0]         r_mem1 [0:H_ACTIVE-1];

    logic               w_pstb;
    logic               w_resync;
    logic               w_tick;
    logic               w_we;
    logic               w_wr_sel;
    logic [8:0]         w_rd_addr;

    assign w_pstb    = vid.PCLK & ~r_pclk;
    assign w_resync  = w_pstb && (vid.PH == 9'd0);
    assign w_tick    = (r_div == c_DIV_LAST);
    assign w_we      = w_pstb && (vid.PH < c_H_ACTIVE) && (vid.PV < c_V_ACTIVE);
    // Pixel 0 of a new line belongs to the buffer that becomes the write side now.
    assign w_wr_sel  = w_resync ? ~r_wsel : r_wsel;
    assign w_rd_addr = (r_ox < c_H_ACTIVE) ? r_ox : 9'd0;

    // Both output passes read the same buffer, so wrapping ox is all a pass needs.
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_pclk       <= 1'b0;
            r_div        <= '0;
            r_ox         <= 9'd0;
            r_pv_play    <= 9'd0;
            r_wsel       <= 1'b0;
            r_seen_start <= 1'b0;
            r_line_valid <= 1'b0;
            r_pce        <= 1'b0;
        end else begin
            r_pclk <= vid.PCLK;
            r_pce  <= w_tick | w_resync;
            if (w_resync) begin
                r_wsel       <= ~r_wsel;
                r_pv_play    <= vid.PV - 9'd1;
                r_line_valid <= r_seen_start;
                r_seen_start <= 1'b1;
                r_ox         <= 9'd0;
                r_div        <= '0;
            end else begin
                r_div <= w_tick ? '0 : r_div + 1'b1;
                if (w_tick) begin
                    r_ox <= (r_ox == c_H_LAST) ? 9'd0 : r_ox + 9'd1;
                end
            end
        end
    end

    always_ff @(posedge MCLK) begin
        if (w_we && !w_wr_sel) begin
            r_mem0[vid.PH] <= vid.POUT;
        end
        if (w_we && w_wr_sel) begin
            r_mem1[vid.PH] <= vid.POUT;
        end
        r_rd_data <= r_wsel ? r_mem0[w_rd_addr] : r_mem1[w_rd_addr];
    end

    // Stage 1 aligns sync/enable with the RAM read; stage 2 publishes on pixel updates only.
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_ld      <= 1'b0;
            r_s1_de   <= 1'b0;
            r_s1_hs   <= 1'b1;
            r_s1_vs   <= 1'b1;
            r_out_de  <= 1'b0;
            r_out_hs  <= 1'b1;
            r_out_vs  <= 1'b1;
            r_out_rgb <= 8'h00;
        end else begin
            r_ld    <= r_pce;
            r_s1_de <= r_line_valid && (r_ox < c_H_ACTIVE) && (r_pv_play < c_V_ACTIVE);
            r_s1_hs <= ~((r_ox >= c_HS_START) && (r_ox < c_HS_END));
            r_s1_vs <= ~((r_pv_play >= c_VS_START) && (r_pv_play < c_VS_END));
            if (r_ld) begin
                r_out_de  <= r_s1_de;
                r_out_hs  <= r_s1_hs;
                r_out_vs  <= r_s1_vs;
                r_out_rgb <= r_s1_de ? r_rd_data : 8'h00;
            end
        end
    end

    assign vid.O_PCE = r_pce;
    assign vid.O_HS  = r_out_hs;
    assign vid.O_VS  = r_out_vs;
    assign vid.O_DE  = r_out_de;
    assign vid.O_RGB = r_out_rgb;

endmodule
`default_nettype wire
